// File: rtl/processador_multiciclo_param.sv
// processador_multiciclo_param
// ----------------------------------------------------------------------------
// Parametrised multicycle processor. All datapath traffic goes over a single
// shared bus. Each instruction is sequenced by a 2-bit step counter (T0..T3).
// The datapath holds a register file R0..R(NUM_REGS-1), an accumulator A, a
// result register G and an instruction register IR.
//
// Handshake (valid/ready): Run acts as the "valid" for the instruction word on
// DIN. The core is "ready" only in T0, which is the one step where Run is
// sampled; Run in any other step is ignored. Done is high for exactly one cycle
// per instruction: the step whose closing edge performs the register write.
// With Run held high, the next fetch happens in the cycle right after Done.
//
// Optional feature macro: STATUS_FLAGS_EN. When it is defined, the Flags
// output {Z,N,C} is added and is updated by ALU ops at their T3 write edge.
//
// Ports:
//   Clock     in   1       rising-edge clock
//   Resetn    in   1       asynchronous active-low reset
//   DIN       in   DATA_W  instruction word (T0), mvi immediate (T1)
//   Run       in   1       start request, sampled only in T0
//   Done      out  1       final step of the current instruction
//   BusWires  out  DATA_W  shared bus value
//   Flags     out  3       {Z,N,C} (STATUS_FLAGS_EN only)
// ----------------------------------------------------------------------------
module processador_multiciclo_param #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [DATA_W-1:0] DIN,
    input  logic              Run,
    output logic              Done,
    output logic [DATA_W-1:0] BusWires
`ifdef STATUS_FLAGS_EN
    ,
    output logic [2:0]        Flags
`endif
);

    localparam int IW       = 3 + 2 * REG_ADDR_W;
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    generate
        if (DATA_W < IW) begin : g_bad_cfg
            $error("DATA_W must be at least 3 + 2*REG_ADDR_W");
        end
    endgenerate

    typedef enum logic [1:0] {T0, T1, T2, T3} tstep_e;
    typedef enum logic [2:0] {
        OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_NOP
    } op_e;

    tstep_e              tstep_q;
    logic [IW-1:0]       ir_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   g_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    op_e                   op;
    logic [REG_ADDR_W-1:0] rx;
    logic [REG_ADDR_W-1:0] ry;
    logic                  is_alu;
    logic [DATA_W-1:0]     bus_d;
    logic [DATA_W-1:0]     alu_d;

    assign op     = op_e'(ir_q[IW-1 -: 3]);
    assign rx     = ir_q[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign ry     = ir_q[REG_ADDR_W-1:0];
    assign is_alu = (op != OP_MV) && (op != OP_MVI) && (op != OP_NOP);

    // Bus source for the current step; undriven steps (T0, nop) read as 0.
    always_comb begin
        bus_d = '0;
        case (tstep_q)
            T1: begin
                case (op)
                    OP_MV:   bus_d = regs_q[ry];
                    OP_MVI:  bus_d = DIN;
                    OP_NOP:  bus_d = '0;
                    default: bus_d = regs_q[rx];
                endcase
            end
            T2:      if (is_alu) bus_d = regs_q[ry];
            T3:      if (is_alu) bus_d = g_q;
            default: bus_d = '0;
        endcase
    end

    assign BusWires = bus_d;
    assign Done     = ((tstep_q == T1) && !is_alu) || ((tstep_q == T3) && is_alu);

    // ALU: A is the left operand, the bus (Ry during T2) the right one.
    always_comb begin
        alu_d = '0;
        case (op)
            OP_ADD:  alu_d = a_q + bus_d;
            OP_SUB:  alu_d = a_q - bus_d;
            OP_AND:  alu_d = a_q & bus_d;
            OP_OR:   alu_d = a_q | bus_d;
            OP_SLT:  alu_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(bus_d))};
            default: alu_d = '0;
        endcase
    end

`ifdef STATUS_FLAGS_EN
    logic [2:0] flags_q;
    logic       carry_d;

    // Carry is recovered from G and A in T3 so no wide sum has to be kept:
    // an add overflowed iff the wrapped result is below A; a sub did not
    // borrow iff the result does not exceed A.
    always_comb begin
        carry_d = 1'b0;
        case (op)
            OP_ADD:  carry_d = (g_q < a_q);
            OP_SUB:  carry_d = (g_q <= a_q);
            default: carry_d = 1'b0;
        endcase
    end

    assign Flags = flags_q;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            tstep_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef STATUS_FLAGS_EN
            flags_q <= '0;
`endif
        end else begin
            case (tstep_q)
                T0: begin
                    if (Run) begin
                        ir_q    <= DIN[IW-1:0];
                        tstep_q <= T1;
                    end
                end
                T1: begin
                    if (is_alu) begin
                        a_q     <= bus_d;
                        tstep_q <= T2;
                    end else begin
                        if (op != OP_NOP) regs_q[rx] <= bus_d;
                        tstep_q <= T0;
                    end
                end
                T2: begin
                    g_q     <= alu_d;
                    tstep_q <= T3;
                end
                T3: begin
                    regs_q[rx] <= bus_d;
`ifdef STATUS_FLAGS_EN
                    flags_q <= {(g_q == '0), g_q[DATA_W-1], carry_d};
`endif
                    tstep_q <= T0;
                end
                default: tstep_q <= T0;
            endcase
        end
    end

endmodule

// File: tb/tb_processador_multiciclo_param.sv
// Bench for processador_multiciclo_param: a cycle-timed driver issues
// instructions, a reference model predicts the per-cycle Done/bus/flags
// response into a queue, and a negedge monitor pops and compares.
module tb_processador_multiciclo_param;
  localparam int DATA_W = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS = 8;
  localparam int unsigned MASK = 32'h0000_FFFF;
  localparam int EW = 1 + DATA_W + 3;

  localparam int OP_MV = 0, OP_MVI = 1, OP_ADD = 2, OP_SUB = 3;
  localparam int OP_AND = 4, OP_OR = 5, OP_SLT = 6, OP_NOP = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic [DATA_W-1:0] din;
  logic run;
  logic done;
  logic [DATA_W-1:0] bus;
`ifdef STATUS_FLAGS_EN
  logic [2:0] flags;
`endif

  always #5 clk = ~clk;

  processador_multiciclo_param #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .Clock(clk),
    .Resetn(rst_n),
    .DIN(din),
    .Run(run),
    .Done(done),
    .BusWires(bus)
`ifdef STATUS_FLAGS_EN
    ,
    .Flags(flags)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];   // {done, bus, flags} per cycle
  int n_checks = 0;
  int n_pass = 0;

  int unsigned m_reg[NUM_REGS];
  logic [2:0] m_flags;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic push(input logic d, input int unsigned b);
    exp_q.push_back({d, b[DATA_W-1:0], m_flags});
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_reg[i] = 0;
    m_flags = 3'b000;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n === 1'b1) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("done", 32'(done), 32'(e[EW-1]));
        check("bus", 32'(bus), 32'(e[EW-2 -: DATA_W]));
`ifdef STATUS_FLAGS_EN
        check("flags", 32'(flags), 32'(e[2:0]));
`endif
      end else begin
        check("idle_done", 32'(done), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      run = 1'b0;
      din = DATA_W'($urandom);
      push(1'b0, 0);
    end
  endtask

  function automatic logic [DATA_W-1:0] encode(input int op, input int x, input int y);
    logic [8:0] iw;
    iw = 9'((op << 6) | (x << 3) | y);
    return {7'($urandom), iw};   // bits above the instruction field are don't-care
  endfunction

  function automatic int to_signed(input int unsigned v);
    return (v >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  task automatic issue(input int op, input int x, input int y, input int unsigned imm);
    int unsigned a, b, res, s;
    logic c;
    cyc();
    run = 1'b1;
    din = encode(op, x, y);
    push(1'b0, 0);
    if (op == OP_MV || op == OP_MVI || op == OP_NOP) begin
      cyc();
      run = 1'($urandom);
      din = (op == OP_MVI) ? DATA_W'(imm) : DATA_W'($urandom);
      res = (op == OP_MV) ? m_reg[y] : (op == OP_MVI) ? (imm & MASK) : 0;
      push(1'b1, res);
      if (op != OP_NOP) m_reg[x] = res;
    end else begin
      a = m_reg[x];
      b = m_reg[y];
      c = 1'b0;
      case (op)
        OP_ADD: begin s = a + b; res = s & MASK; c = (s > MASK); end
        OP_SUB: begin res = (a - b) & MASK; c = (a >= b); end
        OP_AND: res = a & b;
        OP_OR:  res = a | b;
        default: res = (to_signed(a) < to_signed(b)) ? 1 : 0;
      endcase
      cyc(); run = 1'($urandom); din = DATA_W'($urandom); push(1'b0, a);
      cyc(); run = 1'($urandom); din = DATA_W'($urandom); push(1'b0, b);
      cyc(); run = 1'($urandom); din = DATA_W'($urandom); push(1'b1, res);
      m_reg[x] = res;
      m_flags = {res == 0, res >= 32768, c};
    end
  endtask

  // Start an add, then pull reset low in the middle of its T2 step.
  task automatic reset_mid_alu(input int x, input int y);
    cyc(); run = 1'b1; din = encode(OP_ADD, x, y); push(1'b0, 0);
    cyc(); run = 1'b0; push(1'b0, m_reg[x]);
    cyc();
    rst_n = 1'b0;
    #1;
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_bus", 32'(bus), 32'd0);
`ifdef STATUS_FLAGS_EN
    check("rst_mid_flags", 32'(flags), 32'd0);
`endif
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int op;
    rst_n = 1'b0;
    run = 1'b0;
    din = '0;
    model_reset();
    #1;
    check("reset_done", 32'(done), 32'd0);
    check("reset_bus", 32'(bus), 32'd0);
`ifdef STATUS_FLAGS_EN
    check("reset_flags", 32'(flags), 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // directed sequence
    issue(OP_MVI, 0, 0, 32'h0005);
    issue(OP_MVI, 1, 0, 32'h0003);
    issue(OP_MV, 2, 0, 0);
    issue(OP_ADD, 0, 1, 0);
    issue(OP_MVI, 3, 0, 32'h0000);
    issue(OP_MVI, 4, 0, 32'h0001);
    issue(OP_SUB, 3, 4, 0);
    idle(3);
    issue(OP_MVI, 5, 0, 32'h8000);
    issue(OP_MVI, 6, 0, 32'h0001);
    issue(OP_SLT, 5, 6, 0);
    issue(OP_SLT, 6, 5, 0);
    issue(OP_ADD, 1, 1, 0);
    issue(OP_MVI, 2, 0, 32'hFFFF);
    issue(OP_ADD, 2, 1, 0);
    issue(OP_AND, 2, 1, 0);
    issue(OP_OR, 2, 6, 0);
    issue(OP_NOP, 3, 4, 0);
    issue(OP_SUB, 4, 4, 0);

    // reset in the middle of an ALU op leaves no write
    issue(OP_MVI, 0, 0, 32'h1234);
    reset_mid_alu(0, 1);
    issue(OP_MV, 7, 0, 0);
    issue(OP_ADD, 0, 7, 0);

    // randomized stream
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      issue(op, int'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(0, NUM_REGS - 1)),
            (($urandom_range(0, 3) == 0) ? 32'h8000 : 32'h0) | $urandom_range(0, 32'hFFFF));
    end

    idle(3);
    run = 1'b0;
    @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
